// File: rtl/anim_pkg.sv
// rtl/anim_pkg.sv - shared types, base segment table and state encoding for the line animator
//
// Purpose: constants and types used by line_animator and anim_offset.
//   MAX_LINES   - capacity of the base segment table
//   LIDX_W      - width of a segment index
//   line_t      - one segment, endpoints (x0,y0)-(x1,y1)
//   BASE_LINES  - segment positions at offset 0
//   state_e     - sequencer states
//   MODE_*      - values of the mode input
package anim_pkg;

  localparam int MAX_LINES = 4;
  localparam int LIDX_W    = $clog2(MAX_LINES);

  localparam logic MODE_BOUNCE = 1'b0;
  localparam logic MODE_WRAP   = 1'b1;

  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] x1;
    logic [15:0] y1;
  } line_t;

  // Entry 1 sits on the screen corner so offsets push it into the clamp.
  localparam line_t BASE_LINES [MAX_LINES] = '{
    '{x0: 16'd30,  y0: 16'd100, x1: 16'd100, y1: 16'd30 },
    '{x0: 16'd639, y0: 16'd479, x1: 16'd320, y1: 16'd240},
    '{x0: 16'd0,   y0: 16'd0,   x1: 16'd200, y1: 16'd150},
    '{x0: 16'd0,   y0: 16'd479, x1: 16'd200, y1: 16'd300}
  };

  typedef enum logic [2:0] {
    S_START,
    S_CLEAR_REQ,
    S_CLEAR_WAIT,
    S_SETTLE,
    S_DRAW,
    S_STEP
  } state_e;

endpackage

// File: rtl/anim_offset.sv
// rtl/anim_offset.sv - shared segment offset with bounce / wrap stepping
//
// Purpose: holds the offset applied to every segment and its travel
// direction, and advances them once per frame.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   enable        low = hold offset and direction
//   restart       synchronous return to offset 0, direction up
//   step          advance this cycle (sequencer is in STEP)
//   mode          0 = bounce, 1 = wrap
//   off_next      value the offset holds after this cycle (equals the
//                 current offset whenever no step is taken)
module anim_offset
  import anim_pkg::*;
#(
  parameter int STEPS = 250,
  parameter int STEP  = 1,
  parameter int OFF_W = $clog2(STEPS * STEP + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             restart,
  input  logic             step,
  input  logic             mode,
  output logic [OFF_W-1:0] off_next
);

  localparam logic [OFF_W-1:0] LIMIT  = OFF_W'(STEPS * STEP);
  localparam logic [OFF_W-1:0] STEP_V = OFF_W'(STEP);

  logic [OFF_W-1:0] off;
  logic             dir_down;
  logic             dir_next;

  always_comb begin
    off_next = off;
    dir_next = dir_down;
    if (enable && step) begin
      if (mode == MODE_WRAP) begin
        // Direction is left alone so a later switch to bounce keeps heading
        // the same way.
        off_next = (off >= LIMIT) ? '0 : off + STEP_V;
      end else if (!dir_down) begin
        if (off >= LIMIT) begin
          off_next = LIMIT - STEP_V;
          dir_next = 1'b1;
        end else if (off + STEP_V >= LIMIT) begin
          // Turn in the same step that reaches the end: no repeated frame.
          off_next = LIMIT;
          dir_next = 1'b1;
        end else begin
          off_next = off + STEP_V;
        end
      end else begin
        if (off == '0) begin
          off_next = STEP_V;
          dir_next = 1'b0;
        end else if (off <= STEP_V) begin
          off_next = '0;
          dir_next = 1'b0;
        end else begin
          off_next = off - STEP_V;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      off      <= '0;
      dir_down <= 1'b0;
    end else if (restart) begin
      off      <= '0;
      dir_down <= 1'b0;
    end else begin
      off      <= off_next;
      dir_down <= dir_next;
    end
  end

endmodule

// File: rtl/line_animator.sv
// rtl/line_animator.sv - frame sequencer driving the screen clearer and line drawer
//
// Purpose: per frame, requests a screen clear and waits for the clearer to
// finish, draws N_LINES segments (each offset and clamped), then steps the
// shared offset.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   enable         low = freeze all state and outputs
//   restart        one-cycle pulse, same effect as reset
//   mode           0 = bounce, 1 = wrap
//   clear_busy     screen clearer busy
//   clear_req      one-cycle clear start pulse
//   drawer_reset   line drawer reset, low only while drawing
//   x0, y0, x1, y1 endpoints of the segment being drawn
//   line_idx       index of the segment being drawn
//   frame_done     one-cycle pulse per completed frame
module line_animator
  import anim_pkg::*;
#(
  parameter int X_W           = 10,
  parameter int Y_W           = 9,
  parameter int N_LINES       = 2,
  parameter int SETTLE_CYCLES = 5,
  parameter int DRAW_CYCLES   = 400000,
  parameter int STEPS         = 250,
  parameter int STEP          = 1,
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int CLEAR_MAX     = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              restart,
  input  logic              mode,
  input  logic              clear_busy,
  output logic              clear_req,
  output logic              drawer_reset,
  output logic [X_W-1:0]    x0,
  output logic [Y_W-1:0]    y0,
  output logic [X_W-1:0]    x1,
  output logic [Y_W-1:0]    y1,
  output logic [LIDX_W-1:0] line_idx,
  output logic              frame_done
);

  localparam int OFF_W   = $clog2(STEPS * STEP + 1);
  localparam int CNT_A   = (DRAW_CYCLES > CLEAR_MAX) ? DRAW_CYCLES : CLEAR_MAX;
  localparam int CNT_TOP = (CNT_A > SETTLE_CYCLES) ? CNT_A : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DRAW_LAST   = CNT_W'(DRAW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CLEAR_LAST  = CNT_W'(CLEAR_MAX - 1);
  localparam logic [LIDX_W-1:0] LAST_IDX    = LIDX_W'(N_LINES - 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              seen_busy;
  logic              frame_drawn;
  logic [OFF_W-1:0]  off_next;
  logic [LIDX_W-1:0] ld_idx;
  logic [X_W-1:0]    ld_x0;
  logic [Y_W-1:0]    ld_y0;
  logic [X_W-1:0]    ld_x1;
  logic [Y_W-1:0]    ld_y1;

  anim_offset #(
    .STEPS (STEPS),
    .STEP  (STEP),
    .OFF_W (OFF_W)
  ) u_offset (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .restart  (restart),
    .step     (state == S_STEP),
    .mode     (mode),
    .off_next (off_next)
  );

  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] base,
                                             input logic [OFF_W-1:0] o);
    logic [X_W:0] sum;
    sum = {1'b0, base} + (X_W+1)'(o);
    return (sum > (X_W+1)'(X_MAX)) ? X_W'(X_MAX) : sum[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] base,
                                             input logic [OFF_W-1:0] o);
    logic [Y_W:0] sum;
    sum = {1'b0, base} + (Y_W+1)'(o);
    return (sum > (Y_W+1)'(Y_MAX)) ? Y_W'(Y_MAX) : sum[Y_W-1:0];
  endfunction

  // Endpoints for the segment about to enter SETTLE. off_next already holds
  // the stepped offset when leaving STEP, so the new frame sees it at once.
  always_comb begin
    ld_idx = (state == S_DRAW) ? line_idx + 1'b1 : line_idx;
    ld_x0  = clamp_x(X_W'(BASE_LINES[ld_idx].x0), off_next);
    ld_y0  = clamp_y(Y_W'(BASE_LINES[ld_idx].y0), off_next);
    ld_x1  = clamp_x(X_W'(BASE_LINES[ld_idx].x1), off_next);
    ld_y1  = clamp_y(Y_W'(BASE_LINES[ld_idx].y1), off_next);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_START;
      cnt          <= '0;
      seen_busy    <= 1'b0;
      frame_drawn  <= 1'b0;
      line_idx     <= '0;
      clear_req    <= 1'b0;
      drawer_reset <= 1'b1;
      frame_done   <= 1'b0;
      x0           <= X_W'(BASE_LINES[0].x0);
      y0           <= Y_W'(BASE_LINES[0].y0);
      x1           <= X_W'(BASE_LINES[0].x1);
      y1           <= Y_W'(BASE_LINES[0].y1);
    end else if (restart) begin
      state        <= S_START;
      cnt          <= '0;
      seen_busy    <= 1'b0;
      frame_drawn  <= 1'b0;
      line_idx     <= '0;
      clear_req    <= 1'b0;
      drawer_reset <= 1'b1;
      frame_done   <= 1'b0;
      x0           <= X_W'(BASE_LINES[0].x0);
      y0           <= Y_W'(BASE_LINES[0].y0);
      x1           <= X_W'(BASE_LINES[0].x1);
      y1           <= Y_W'(BASE_LINES[0].y1);
    end else if (enable) begin
      case (state)
        S_START: begin
          state     <= S_CLEAR_REQ;
          clear_req <= 1'b1;
        end

        S_CLEAR_REQ: begin
          state     <= S_CLEAR_WAIT;
          clear_req <= 1'b0;
          cnt       <= '0;
          seen_busy <= 1'b0;
        end

        // Done once busy has been seen high and has dropped again; the
        // counter covers a clearer that never answers.
        S_CLEAR_WAIT: begin
          if (clear_busy) begin
            seen_busy <= 1'b1;
          end
          if ((seen_busy && !clear_busy) || cnt == CLEAR_LAST) begin
            cnt       <= '0;
            seen_busy <= 1'b0;
            if (frame_drawn) begin
              state       <= S_STEP;
              frame_done  <= 1'b1;
              frame_drawn <= 1'b0;
            end else begin
              state <= S_SETTLE;
              x0    <= ld_x0;
              y0    <= ld_y0;
              x1    <= ld_x1;
              y1    <= ld_y1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STEP: begin
          state      <= S_SETTLE;
          frame_done <= 1'b0;
          x0         <= ld_x0;
          y0         <= ld_y0;
          x1         <= ld_x1;
          y1         <= ld_y1;
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state        <= S_DRAW;
            drawer_reset <= 1'b0;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DRAW: begin
          if (cnt == DRAW_LAST) begin
            cnt          <= '0;
            drawer_reset <= 1'b1;
            if (line_idx == LAST_IDX) begin
              state       <= S_CLEAR_REQ;
              clear_req   <= 1'b1;
              line_idx    <= '0;
              frame_drawn <= 1'b1;
            end else begin
              state    <= S_SETTLE;
              line_idx <= ld_idx;
              x0       <= ld_x0;
              y0       <= ld_y0;
              x1       <= ld_x1;
              y1       <= ld_y1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state        <= S_START;
          clear_req    <= 1'b0;
          drawer_reset <= 1'b1;
          frame_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_animator.sv
// tb/tb_line_animator.sv - directed self-checking bench for line_animator
module tb_line_animator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       restart;
  logic       mode;
  logic       clear_busy;
  logic       clear_req;
  logic       drawer_reset;
  logic [9:0] x0;
  logic [8:0] y0;
  logic [9:0] x1;
  logic [8:0] y1;
  logic [1:0] line_idx;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  bit busy_model = 1'b1;
  int busy_left  = 0;

  line_animator #(
    .X_W           (10),
    .Y_W           (9),
    .N_LINES       (2),
    .SETTLE_CYCLES (3),
    .DRAW_CYCLES   (20),
    .STEPS         (3),
    .STEP          (1),
    .X_MAX         (639),
    .Y_MAX         (479),
    .CLEAR_MAX     (50)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .restart      (restart),
    .mode         (mode),
    .clear_busy   (clear_busy),
    .clear_req    (clear_req),
    .drawer_reset (drawer_reset),
    .x0           (x0),
    .y0           (y0),
    .x1           (x1),
    .y1           (y1),
    .line_idx     (line_idx),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Screen clearer model: busy for 10 cycles starting with the clear_req cycle.
  initial begin
    clear_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_model && clear_req === 1'b1) busy_left = 10;
      if (busy_left > 0) begin
        clear_busy = 1'b1;
        busy_left--;
      end else begin
        clear_busy = 1'b0;
      end
    end
  end

  function automatic bit probe(input int which);
    case (which)
      0:       return clear_req === 1'b1;
      1:       return frame_done === 1'b1;
      2:       return drawer_reset === 1'b1;
      default: return drawer_reset === 1'b0;
    endcase
  endfunction

  // Counts negedges until the probed condition holds (0 if it already does).
  task automatic wait_for(input int which, input int limit, output bit ok, output int n);
    n  = 0;
    ok = probe(which);
    while (!ok && n < limit) begin
      @(negedge clk);
      n++;
      ok = probe(which);
    end
  endtask

  task automatic next_line0(output bit ok);
    int n;
    n = 0;
    while (drawer_reset !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (!(drawer_reset === 1'b0 && line_idx === 2'd0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    ok = (drawer_reset === 1'b0 && line_idx === 2'd0);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int n;
    reset_n = 1'b0;
    enable  = 1'b1;
    restart = 1'b0;
    mode    = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (clear_req !== 1'b0 || drawer_reset !== 1'b1 || frame_done !== 1'b0 || line_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: clear_req=%b drawer_reset=%b frame_done=%b line_idx=%0d, expected 0 1 0 0",
               clear_req, drawer_reset, frame_done, line_idx);
    end
    n_tests++;
    if ({x0, y0, x1, y1} !== {10'd30, 9'd100, 10'd100, 9'd30}) begin
      n_fail++;
      $display("FAIL reset_coords: (%0d,%0d)-(%0d,%0d), expected (30,100)-(100,30)", x0, y0, x1, y1);
    end
    reset_n = 1'b1;
    n_tests++;
    if (clear_req !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_req_cycle1: got %b, expected 0", clear_req);
    end
    @(negedge clk);
    n_tests++;
    if (clear_req !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_req_cycle2: got %b, expected 1", clear_req);
    end
    @(negedge clk);
    n_tests++;
    if (clear_req !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_req_one_cycle: got %b, expected 0", clear_req);
    end
    wait_for(3, 100, ok, n);
    n_tests++;
    if (!ok || n != 13) begin
      n_fail++;
      $display("FAIL first_draw_latency: %0d cycles after clear_req (found=%0d), expected 14", n + 1, ok);
    end
    n_tests++;
    if (line_idx !== 2'd0 || {x0, y0, x1, y1} !== {10'd30, 9'd100, 10'd100, 9'd30}) begin
      n_fail++;
      $display("FAIL first_line0: idx=%0d (%0d,%0d)-(%0d,%0d), expected idx 0 (30,100)-(100,30)",
               line_idx, x0, y0, x1, y1);
    end
  endtask

  task automatic test_one_frame();
    bit ok;
    int n;
    n = 0;
    while (drawer_reset === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_tests++;
    if (n != 20) begin
      n_fail++;
      $display("FAIL line0_draw_len: %0d cycles, expected 20", n);
    end
    n_tests++;
    if (line_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL line_idx_advance: got %0d, expected 1", line_idx);
    end
    n = 0;
    while (drawer_reset === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_tests++;
    if (n != 3) begin
      n_fail++;
      $display("FAIL line1_settle_len: %0d cycles, expected 3", n);
    end
    n_tests++;
    if ({x0, y0, x1, y1} !== {10'd639, 9'd479, 10'd320, 9'd240}) begin
      n_fail++;
      $display("FAIL line1_coords: (%0d,%0d)-(%0d,%0d), expected (639,479)-(320,240)", x0, y0, x1, y1);
    end
    n = 0;
    while (drawer_reset === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_tests++;
    if (n != 20) begin
      n_fail++;
      $display("FAIL line1_draw_len: %0d cycles, expected 20", n);
    end
    n_tests++;
    if (clear_req !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_req_after_frame: got %b, expected 1", clear_req);
    end
    wait_for(1, 100, ok, n);
    n_tests++;
    if (!ok || n != 11) begin
      n_fail++;
      $display("FAIL clear_to_frame_done: %0d cycles (found=%0d), expected 11", n, ok);
    end
    @(negedge clk);
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done_pulse: got %b one cycle later, expected 0", frame_done);
    end
    wait_for(3, 100, ok, n);
    n_tests++;
    if (!ok || line_idx !== 2'd0 || {x0, y0, x1, y1} !== {10'd31, 9'd101, 10'd101, 9'd31}) begin
      n_fail++;
      $display("FAIL frame2_line0: idx=%0d (%0d,%0d)-(%0d,%0d), expected idx 0 (31,101)-(101,31)",
               line_idx, x0, y0, x1, y1);
    end
  endtask

  task automatic test_bounce();
    int exp_off [9] = '{0, 1, 2, 3, 2, 1, 0, 1, 2};
    bit ok;
    mode = 1'b0;
    do_restart();
    for (int f = 0; f < 9; f++) begin
      next_line0(ok);
      n_tests++;
      if (!ok || x0 !== 10'(30 + exp_off[f]) || y0 !== 9'(100 + exp_off[f])) begin
        n_fail++;
        $display("FAIL bounce_frame%0d: x0=%0d y0=%0d, expected x0=%0d y0=%0d",
                 f, x0, y0, 30 + exp_off[f], 100 + exp_off[f]);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_off [6] = '{0, 1, 2, 3, 0, 1};
    bit ok;
    mode = 1'b1;
    do_restart();
    for (int f = 0; f < 6; f++) begin
      next_line0(ok);
      n_tests++;
      if (!ok || x0 !== 10'(30 + exp_off[f]) || y1 !== 9'(30 + exp_off[f])) begin
        n_fail++;
        $display("FAIL wrap_frame%0d: x0=%0d y1=%0d, expected x0=%0d y1=%0d",
                 f, x0, y1, 30 + exp_off[f], 30 + exp_off[f]);
      end
    end
  endtask

  task automatic test_timeout_enable();
    bit ok;
    int n;
    int held;
    busy_model = 1'b0;
    mode       = 1'b0;
    do_restart();
    wait_for(0, 20, ok, n);
    wait_for(3, 200, ok, n);
    n_tests++;
    if (!ok || n != 54) begin
      n_fail++;
      $display("FAIL timeout_exit: first draw %0d cycles after clear_req (found=%0d), expected 54", n, ok);
    end
    n = 0;
    while (drawer_reset === 1'b0 && n < 100) begin
      n++;
      if (n == 5)  enable = 1'b0;
      if (n == 12) enable = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (n != 27) begin
      n_fail++;
      $display("FAIL enable_stretch: draw window %0d cycles, expected 27", n);
    end
    wait_for(0, 200, ok, n);
    enable = 1'b0;
    held   = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (clear_req === 1'b1) held++;
    end
    n_tests++;
    if (!ok || held != 3) begin
      n_fail++;
      $display("FAIL clear_req_held: high %0d of 3 frozen cycles (found=%0d), expected 3", held, ok);
    end
    enable = 1'b1;
    @(negedge clk);
    n_tests++;
    if (clear_req !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_req_release: got %b, expected 0", clear_req);
    end
    wait_for(0, 300, ok, n);
    wait_for(1, 200, ok, n);
    n_tests++;
    if (!ok || n != 51) begin
      n_fail++;
      $display("FAIL timeout_frame_done: %0d cycles after clear_req (found=%0d), expected 51", n, ok);
    end
  endtask

  task automatic test_restart_clamp();
    bit ok;
    int n;
    busy_model = 1'b1;
    mode       = 1'b0;
    do_restart();
    for (int f = 0; f < 3; f++) next_line0(ok);
    n_tests++;
    if (!ok || x0 !== 10'd32) begin
      n_fail++;
      $display("FAIL off2_line0: x0=%0d, expected 32", x0);
    end
    wait_for(2, 50, ok, n);
    wait_for(3, 50, ok, n);
    n_tests++;
    if (!ok || line_idx !== 2'd1 || {x0, y0, x1, y1} !== {10'd639, 9'd479, 10'd322, 9'd242}) begin
      n_fail++;
      $display("FAIL clamp_line1: idx=%0d (%0d,%0d)-(%0d,%0d), expected idx 1 (639,479)-(322,242)",
               line_idx, x0, y0, x1, y1);
    end
    repeat (5) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    n_tests++;
    if (drawer_reset !== 1'b1 || line_idx !== 2'd0 || x0 !== 10'd30 || y0 !== 9'd100) begin
      n_fail++;
      $display("FAIL restart_state: drawer_reset=%b idx=%0d x0=%0d y0=%0d, expected 1 0 30 100",
               drawer_reset, line_idx, x0, y0);
    end
    @(negedge clk);
    n_tests++;
    if (clear_req !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear_req: got %b, expected 1", clear_req);
    end
    next_line0(ok);
    n_tests++;
    if (!ok || x0 !== 10'd30) begin
      n_fail++;
      $display("FAIL restart_off0: x0=%0d, expected 30", x0);
    end
    next_line0(ok);
    n_tests++;
    if (!ok || x0 !== 10'd31) begin
      n_fail++;
      $display("FAIL restart_dir_up: x0=%0d, expected 31", x0);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (drawer_reset !== 1'b1 || x0 !== 10'd30) begin
      n_fail++;
      $display("FAIL async_reset_draw: drawer_reset=%b x0=%0d, expected 1 30", drawer_reset, x0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (clear_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_reclear: got %b, expected 1", clear_req);
    end
  endtask

  initial begin
    test_reset();
    test_one_frame();
    test_bounce();
    test_wrap();
    test_timeout_enable();
    test_restart_clamp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
